person_link: RTL and testbench

PERSON_LINK -- requirements
Module: person_link

---
 rtl/person_link.sv | 163 ++++++++++++++++
 tb/tb_person_link.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/person_link.sv
// Person-code link: 4-bit code exchanged over a 6-wire req/ack handshake.
// Ports: clk, rst, tx_person/tx_start in; pmod_in/pmod_out link; tx_busy, tx_done, link_err, rx_person, rx_valid out.
module person_link #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] tx_person,
  input  logic       tx_start,
  input  logic [5:0] pmod_in,
  output logic [5:0] pmod_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       link_err,
  output logic [3:0] rx_person,
  output logic       rx_valid
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    T_IDLE, T_SETUP, T_REQ, T_REL, T_DONE
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE, R_ACK, R_WAIT
  } rx_state_e;

  logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
  logic [3:0] data_s;
  logic       req_s, ack_s;

  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;

  logic [3:0]    tx_reg_q, tx_reg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          link_err_q, link_err_d;
  logic          req_q, req_d;
  logic          ack_q, ack_d;
  logic          tx_busy_q, tx_busy_d;
  logic          tx_done_q, tx_done_d;
  logic [3:0]    rx_person_q, rx_person_d;
  logic          rx_valid_q, rx_valid_d;

  // Data and req travel the same sync depth; data is set up one
  // cycle ahead of req, so data_s is stable when req_s rises.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pmod_in};
  end

  assign data_s = sync_q[SYNC_STAGES-1][3:0];
  assign req_s  = sync_q[SYNC_STAGES-1][4];
  assign ack_s  = sync_q[SYNC_STAGES-1][5];

  always_comb begin
    tx_state_d = tx_state_q;
    tx_reg_d   = tx_reg_q;
    cnt_d      = cnt_q;
    link_err_d = link_err_q;
    unique case (tx_state_q)
      T_IDLE: begin
        if (tx_start) begin
          tx_reg_d   = tx_person;
          link_err_d = 1'b0;
          tx_state_d = T_SETUP;
        end
      end
      T_SETUP: begin
        cnt_d      = '0;
        tx_state_d = T_REQ;
      end
      T_REQ: begin
        if (ack_s) begin
          cnt_d      = '0;
          tx_state_d = T_REL;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          cnt_d      = '0;
          link_err_d = 1'b1;
          tx_state_d = T_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      T_REL: begin
        if (!ack_s) begin
          cnt_d      = '0;
          tx_state_d = T_DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          cnt_d      = '0;
          link_err_d = 1'b1;
          tx_state_d = T_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      T_DONE: tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
    // Outputs are registered from the next state.
    req_d     = (tx_state_d == T_REQ);
    tx_busy_d = (tx_state_d != T_IDLE);
    tx_done_d = (tx_state_d == T_DONE);
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_person_d = rx_person_q;
    rx_valid_d  = 1'b0;
    unique case (rx_state_q)
      R_IDLE: begin
        if (req_s) begin
          rx_person_d = data_s;
          rx_valid_d  = 1'b1;
          rx_state_d  = R_ACK;
        end
      end
      R_ACK:  rx_state_d = R_WAIT;
      R_WAIT: if (!req_s) rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
    ack_d = (rx_state_d != R_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      tx_state_q  <= T_IDLE;
      rx_state_q  <= R_IDLE;
      tx_reg_q    <= '0;
      cnt_q       <= '0;
      link_err_q  <= 1'b0;
      req_q       <= 1'b0;
      ack_q       <= 1'b0;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      rx_person_q <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      tx_state_q  <= tx_state_d;
      rx_state_q  <= rx_state_d;
      tx_reg_q    <= tx_reg_d;
      cnt_q       <= cnt_d;
      link_err_q  <= link_err_d;
      req_q       <= req_d;
      ack_q       <= ack_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
      rx_person_q <= rx_person_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign pmod_out  = {ack_q, req_q, tx_reg_q};
  assign tx_busy   = tx_busy_q;
  assign tx_done   = tx_done_q;
  assign link_err  = link_err_q;
  assign rx_person = rx_person_q;
  assign rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_person_link.sv
// Bench for person_link: A/B cross-wired loopback plus a lone
// instance C (pmod_in tied low) for the timeout path.
module tb_person_link;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic [3:0] a_person, b_person, c_person;
  logic a_start, b_start, c_start;
  logic [5:0] a_out, b_out, c_out;
  logic [5:0] zero_in;
  logic a_busy, a_done, a_err, a_rxv;
  logic b_busy, b_done, b_err, b_rxv;
  logic c_busy, c_done, c_err, c_rxv;
  logic [3:0] a_rxp, b_rxp, c_rxp;

  person_link #(.SYNC_STAGES(2), .TIMEOUT_CYC(200)) u_a (
    .clk(clk), .rst(rst_a), .tx_person(a_person), .tx_start(a_start),
    .pmod_in(b_out), .pmod_out(a_out), .tx_busy(a_busy),
    .tx_done(a_done), .link_err(a_err), .rx_person(a_rxp),
    .rx_valid(a_rxv)
  );

  person_link #(.SYNC_STAGES(2), .TIMEOUT_CYC(200)) u_b (
    .clk(clk), .rst(rst_b), .tx_person(b_person), .tx_start(b_start),
    .pmod_in(a_out), .pmod_out(b_out), .tx_busy(b_busy),
    .tx_done(b_done), .link_err(b_err), .rx_person(b_rxp),
    .rx_valid(b_rxv)
  );

  person_link #(.SYNC_STAGES(2), .TIMEOUT_CYC(16)) u_c (
    .clk(clk), .rst(rst_c), .tx_person(c_person), .tx_start(c_start),
    .pmod_in(zero_in), .pmod_out(c_out), .tx_busy(c_busy),
    .tx_done(c_done), .link_err(c_err), .rx_person(c_rxp),
    .rx_valid(c_rxv)
  );

  int tests = 0;
  int fails = 0;
  int c_done_cnt = 0;

  logic [3:0] exp_rx_a[$];
  logic [3:0] exp_rx_b[$];
  logic       exp_done_a[$];
  logic       exp_done_b[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    tests++;
    fails++;
    $display("FAIL %s: got event value %0d, expected no event", name, act);
  endtask

  // Monitor: pops expected responses whenever the DUTs present output.
  always @(negedge clk) begin
    if (!rst_b && b_rxv) begin
      if (exp_rx_b.size() == 0) unexpected("b_rx_valid", int'(b_rxp));
      else check("b_rx_person", int'(b_rxp), int'(exp_rx_b.pop_front()));
    end
    if (!rst_a && a_rxv) begin
      if (exp_rx_a.size() == 0) unexpected("a_rx_valid", int'(a_rxp));
      else check("a_rx_person", int'(a_rxp), int'(exp_rx_a.pop_front()));
    end
    if (!rst_a && a_done) begin
      if (exp_done_a.size() == 0) unexpected("a_tx_done", 1);
      else check("a_done_err", int'(a_err), int'(!exp_done_a.pop_front()));
    end
    if (!rst_b && b_done) begin
      if (exp_done_b.size() == 0) unexpected("b_tx_done", 1);
      else check("b_done_err", int'(b_err), int'(!exp_done_b.pop_front()));
    end
    if (!rst_c && c_done) c_done_cnt++;
  end

  function automatic logic cond(input int sel);
    case (sel)
      0: return !a_busy;
      1: return !b_busy;
      2: return b_out[5];
      3: return !b_out[5];
      default: return !a_busy && !b_busy;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel, input int lim);
    int n;
    n = 0;
    while (!cond(sel) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!cond(sel)) begin
      tests++;
      fails++;
      $display("FAIL %s: got timeout after %0d cycles, expected event", name, lim);
    end
  endtask

  task automatic pulse_a(input logic [3:0] p);
    @(negedge clk);
    a_person = p;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  initial begin
    int hi;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    a_person = '0; b_person = '0; c_person = '0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    zero_in = '0;
    repeat (3) @(negedge clk);
    check("rst_pmod_out", int'(a_out), 0);
    check("rst_tx_busy", int'(a_busy), 0);
    check("rst_link_err", int'(a_err), 0);
    check("rst_rx_person", int'(a_rxp), 0);
    check("rst_rx_valid", int'(a_rxv), 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback send 1001 with latency checks.
    exp_rx_b.push_back(4'b1001);
    exp_done_a.push_back(1'b1);
    pulse_a(4'b1001);
    check("lat_req_c1", int'(a_out[4]), 0);
    check("setup_data", int'(a_out[3:0]), 9);
    check("setup_busy", int'(a_busy), 1);
    @(negedge clk);
    check("lat_req_c2", int'(a_out[4]), 1);
    @(negedge clk);
    @(negedge clk);
    check("lat_rxv_early", int'(b_rxv), 0);
    @(negedge clk);
    check("lat_rxv", int'(b_rxv), 1);
    wait_for("send1_idle", 0, 100);
    check("send1_err", int'(a_err), 0);
    check("send1_data_hold", int'(a_out[3:0]), 9);
    wait_for("send1_b_ack_low", 3, 50);
    repeat (3) @(negedge clk);

    // Second tx_start during T_REQ must be ignored.
    exp_rx_b.push_back(4'b0101);
    exp_done_a.push_back(1'b1);
    pulse_a(4'b0101);
    @(negedge clk);
    check("ign_in_req", int'(a_out[4]), 1);
    a_person = 4'b0011;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("ign_data", int'(a_out[3:0]), 5);
    wait_for("send2_idle", 0, 100);
    check("ign_b_rxp", int'(b_rxp), 5);
    repeat (6) @(negedge clk);

    // Simultaneous sends both ways.
    exp_rx_a.push_back(4'b0111);
    exp_rx_b.push_back(4'b0010);
    exp_done_a.push_back(1'b1);
    exp_done_b.push_back(1'b1);
    @(negedge clk);
    a_person = 4'b0010; b_person = 4'b0111;
    a_start = 1'b1; b_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; b_start = 1'b0;
    wait_for("both_idle", 4, 150);
    check("both_a_rxp", int'(a_rxp), 7);
    check("both_b_rxp", int'(b_rxp), 2);
    repeat (6) @(negedge clk);

    // Reset A mid T_REQ; B must drop ack, then a fresh send works.
    exp_rx_b.push_back(4'b0110);
    pulse_a(4'b0110);
    wait_for("rst_b_ack", 2, 50);
    @(negedge clk);
    check("rst_in_req", int'(a_out[4]), 1);
    rst_a = 1'b1;
    #1;
    check("rst_async_out", int'(a_out), 0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    wait_for("rst_b_recover", 3, 50);
    repeat (4) @(negedge clk);
    exp_rx_b.push_back(4'b1100);
    exp_done_a.push_back(1'b1);
    pulse_a(4'b1100);
    wait_for("after_rst_idle", 0, 100);
    check("after_rst_err", int'(a_err), 0);
    check("after_rst_b_rxp", int'(b_rxp), 12);
    repeat (6) @(negedge clk);

    // Timeout on C with nothing answering.
    @(negedge clk);
    c_person = 4'b1010;
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (c_out[4]) hi++;
      else if (hi > 0) break;
    end
    check("to_req_cycles", hi, 16);
    check("to_req_low", int'(c_out[4]), 0);
    check("to_link_err", int'(c_err), 1);
    check("to_busy", int'(c_busy), 0);
    check("to_no_done", c_done_cnt, 0);
    @(negedge clk);
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    check("to_err_clear", int'(c_err), 0);

    repeat (4) @(negedge clk);
    check("left_rx_b", exp_rx_b.size(), 0);
    check("left_rx_a", exp_rx_a.size(), 0);
    check("left_done_a", exp_done_a.size(), 0);
    check("left_done_b", exp_done_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
